// File: rtl/cpu_core_pkg.sv
// Shared core definitions: register width, load/store funct3 encodings and
// the load/store unit's state, error codes and byte-strobe helper.
package cpu_core_pkg;

    localparam int unsigned RSIZE = 32;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        RESP = 2'd3
    } lsu_state_t;

    typedef logic [1:0] lsu_err_t;

    localparam lsu_err_t LSU_OK     = 2'b00;
    localparam lsu_err_t LSU_MISAL  = 2'b01;
    localparam lsu_err_t LSU_BUSERR = 2'b10;
    localparam lsu_err_t LSU_TMO    = 2'b11;

    // funct3[1:0] encodes the access size for both loads and stores.
    function automatic logic [3:0] lsu_wstrb(input logic [2:0] funct3,
                                             input logic [1:0] addr_lo);
        logic [3:0] strb;
        case (funct3[1:0])
            2'b00:   strb = 4'b0001 << addr_lo;
            2'b01:   strb = 4'b0011 << addr_lo;
            default: strb = 4'b1111;
        endcase
        return strb;
    endfunction

endpackage

// File: rtl/cpu_core_lsu_align.sv
// Byte-lane alignment for the LSU: store data replication and strobes, and
// load data shift with sign/zero extension.
module cpu_core_lsu_align
    import cpu_core_pkg::*;
#(
    parameter int unsigned RSIZE = cpu_core_pkg::RSIZE
) (
    input  logic [2:0]       i_funct3,
    input  logic [1:0]       i_addr_lo,
    input  logic [RSIZE-1:0] i_st_data,
    input  logic [RSIZE-1:0] i_rd_word,
    output logic [RSIZE-1:0] o_wdata,
    output logic [3:0]       o_wstrb,
    output logic [RSIZE-1:0] o_ld_data
);

    logic [RSIZE-1:0] w_shifted;

    always_comb begin
        w_shifted = i_rd_word >> {i_addr_lo, 3'b000};

        case (i_funct3)
            F3_LB:   o_ld_data = {{(RSIZE-8){w_shifted[7]}}, w_shifted[7:0]};
            F3_LH:   o_ld_data = {{(RSIZE-16){w_shifted[15]}}, w_shifted[15:0]};
            F3_LW:   o_ld_data = w_shifted;
            F3_LBU:  o_ld_data = {{(RSIZE-8){1'b0}}, w_shifted[7:0]};
            F3_LHU:  o_ld_data = {{(RSIZE-16){1'b0}}, w_shifted[15:0]};
            default: o_ld_data = '0;
        endcase

        case (i_funct3[1:0])
            2'b00:   o_wdata = {(RSIZE/8){i_st_data[7:0]}};
            2'b01:   o_wdata = {(RSIZE/16){i_st_data[15:0]}};
            default: o_wdata = i_st_data;
        endcase

        o_wstrb = lsu_wstrb(i_funct3, i_addr_lo);
    end

endmodule

// File: rtl/cpu_core_lsu.sv
// Load/store unit: one request at a time from execute, a valid/ready
// word-wide data bus, and a single-cycle response pulse to writeback.
module cpu_core_lsu
    import cpu_core_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned RSIZE          = cpu_core_pkg::RSIZE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_is_store,
    input  logic [2:0]       req_funct3,
    input  logic [RSIZE-1:0] req_addr,
    input  logic [RSIZE-1:0] req_wdata,
    input  logic [4:0]       req_rd,
    output logic             rsp_valid,
    output logic [RSIZE-1:0] rsp_rdata,
    output logic [4:0]       rsp_rd,
    output logic             rsp_is_store,
    output logic [1:0]       rsp_err,
    output logic             mem_valid,
    input  logic             mem_ready,
    output logic             mem_we,
    output logic [RSIZE-1:0] mem_addr,
    output logic [3:0]       mem_wstrb,
    output logic [RSIZE-1:0] mem_wdata,
    input  logic             mem_rvalid,
    input  logic [RSIZE-1:0] mem_rdata,
    input  logic             mem_err
);

    lsu_state_t       r_state;
    lsu_state_t       w_state_next;
    logic             r_is_store;
    logic [2:0]       r_funct3;
    logic [RSIZE-1:0] r_addr;
    logic [RSIZE-1:0] r_wdata;
    logic [4:0]       r_rd;
    lsu_err_t         r_err;
    logic [RSIZE-1:0] r_rdata;
    logic [31:0]      r_cnt;

    logic             w_accept;
    logic             w_legal;
    logic             w_tmo;
    logic [RSIZE-1:0] w_wdata;
    logic [3:0]       w_wstrb;
    logic [RSIZE-1:0] w_ld_data;

    cpu_core_lsu_align #(
        .RSIZE(RSIZE)
    ) u_align (
        .i_funct3  (r_funct3),
        .i_addr_lo (r_addr[1:0]),
        .i_st_data (r_wdata),
        .i_rd_word (mem_rdata),
        .o_wdata   (w_wdata),
        .o_wstrb   (w_wstrb),
        .o_ld_data (w_ld_data)
    );

    assign w_accept = req_valid && (r_state == IDLE);
    // Counter holds completed empty DATA cycles; this one would be the next.
    assign w_tmo    = (TIMEOUT_CYCLES != 0) && ((r_cnt + 32'd1) == TIMEOUT_CYCLES);

    always_comb begin
        w_legal = 1'b0;
        if (req_is_store) begin
            case (req_funct3)
                F3_SB:   w_legal = 1'b1;
                F3_SH:   w_legal = !req_addr[0];
                F3_SW:   w_legal = (req_addr[1:0] == 2'b00);
                default: w_legal = 1'b0;
            endcase
        end else begin
            case (req_funct3)
                F3_LB, F3_LBU: w_legal = 1'b1;
                F3_LH, F3_LHU: w_legal = !req_addr[0];
                F3_LW:         w_legal = (req_addr[1:0] == 2'b00);
                default:       w_legal = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: if (w_accept) w_state_next = w_legal ? ADDR : RESP;
            ADDR: if (mem_ready) w_state_next = DATA;
            DATA: if (mem_rvalid || w_tmo) w_state_next = RESP;
            RESP: w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_is_store <= 1'b0;
            r_funct3   <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rd       <= '0;
            r_err      <= LSU_OK;
            r_rdata    <= '0;
            r_cnt      <= '0;
        end else begin
            case (r_state)
                IDLE: if (w_accept) begin
                    r_is_store <= req_is_store;
                    r_funct3   <= req_funct3;
                    r_addr     <= req_addr;
                    r_wdata    <= req_wdata;
                    r_rd       <= req_rd;
                    r_err      <= w_legal ? LSU_OK : LSU_MISAL;
                    r_rdata    <= '0;
                end
                ADDR: if (mem_ready) r_cnt <= '0;
                DATA: begin
                    if (mem_rvalid) begin
                        r_err   <= mem_err ? LSU_BUSERR : LSU_OK;
                        r_rdata <= (mem_err || r_is_store) ? '0 : w_ld_data;
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                        if (w_tmo) r_err <= LSU_TMO;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        req_ready    = (r_state == IDLE);
        mem_valid    = (r_state == ADDR);
        mem_we       = mem_valid && r_is_store;
        mem_addr     = mem_valid ? {r_addr[RSIZE-1:2], 2'b00} : '0;
        mem_wstrb    = mem_we ? w_wstrb : '0;
        mem_wdata    = mem_we ? w_wdata : '0;
        rsp_valid    = (r_state == RESP);
        rsp_rdata    = rsp_valid ? r_rdata : '0;
        rsp_rd       = rsp_valid ? r_rd : '0;
        rsp_is_store = rsp_valid && r_is_store;
        rsp_err      = rsp_valid ? r_err : LSU_OK;
    end

endmodule

// File: doc/cpu_core_lsu.md
Name: cpu_core_lsu

Overview:
- Load/store unit: the memory-side counterpart of the core's load/store funct3 encodings (F3_LB..F3_LHU, F3_SB..F3_SW).
- Accepts one load/store request at a time from the execute stage.
- Drives a word-wide valid/ready data-memory bus, generates byte strobes and lane-replicated write data.
- Returns aligned, sign/zero-extended load data, or an error code, to writeback.

Parameters:
- TIMEOUT_CYCLES, 64: maximum cycles to wait for mem_rvalid after the address handshake; 0 disables the timeout.
- RSIZE, cpu_core_pkg::RSIZE (32): data and address width.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  request valid from execute
- req_ready  out  1  LSU can accept a request
- req_is_store  in  1  1 = store, 0 = load
- req_funct3  in  3  load/store funct3 encoding
- req_addr  in  RSIZE  byte address
- req_wdata  in  RSIZE  store data (rs2)
- req_rd  in  5  load destination register
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  RSIZE  extended load data; 0 for stores and errors
- rsp_rd  out  5  echoed rd
- rsp_is_store  out  1  echoed req_is_store
- rsp_err  out  2  00 ok, 01 misaligned/illegal funct3, 10 bus error, 11 timeout
- mem_valid  out  1  bus address phase valid
- mem_ready  in  1  bus accepts address phase
- mem_we  out  1  write enable
- mem_addr  out  RSIZE  word-aligned address ({req_addr[31:2], 2'b00})
- mem_wstrb  out  4  byte strobes; 0 for reads
- mem_wdata  out  RSIZE  lane-replicated store data
- mem_rvalid  in  1  read data / write ack
- mem_rdata  in  RSIZE  read word
- mem_err  in  1  bus error, qualified by mem_rvalid

Behaviour:
- Reset: state IDLE. All outputs 0 except req_ready. req_ready is 1 after reset.
- Reset mid-operation: the transaction is abandoned and mem_valid drops asynchronously.
- States: IDLE, ADDR, DATA, RESP.
- req_ready is 1 only in IDLE. Accept = req_valid & req_ready; all request fields are registered on accept.
- Legality check at accept:
  - Loads: funct3 must be 000/001/010/100/101.
  - Stores: funct3 must be 000/001/010.
  - LH/LHU/SH require addr[0]=0. LW/SW require addr[1:0]=00.
  - On violation: IDLE->RESP, no bus access, rsp_err=01.
- Legal request: IDLE->ADDR. mem_valid rises the cycle after accept and holds mem_addr/mem_we/mem_wstrb/mem_wdata stable until mem_valid & mem_ready.
- Address handshake: ADDR->DATA. mem_valid deasserts the next cycle. The timeout counter clears.
- DATA state:
  - Waits for mem_rvalid, which the bus may return no earlier than one cycle after the handshake. Each DATA cycle without mem_rvalid increments the counter.
  - When the counter equals TIMEOUT_CYCLES (nonzero), go to RESP with err=11.
  - If mem_rvalid arrives in the same cycle the timeout hits, mem_rvalid wins.
  - mem_rvalid with mem_err=1 gives err=10.
- RESP: rsp_valid=1 for exactly one cycle, then IDLE. Response latency is one cycle after mem_rvalid.
- Store encoding:
  - SB: wdata = {4{b}}, strb = 0001 << addr[1:0].
  - SH: wdata = {2{h}}, strb = 0011 << addr[1:0].
  - SW: strb = 1111.
- Load extraction:
  - Shift mem_rdata right by 8*addr[1:0].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- Stores: rsp_rdata = 0. mem_rvalid is the write ack.
- A late mem_rvalid arriving in IDLE after a timeout is ignored.
- Best-case throughput: one access per 4 cycles when mem_ready and mem_rvalid each respond in the minimum time.

Decomposition:
- cpu_core_pkg gains:
  - lsu_state_t enum (IDLE, ADDR, DATA, RESP).
  - 2-bit lsu_err_t constants LSU_OK, LSU_MISAL, LSU_BUSERR, LSU_TMO.
  - Helper function lsu_wstrb(funct3, addr[1:0]).
- One combinational sub-module, cpu_core_lsu_align: load shift/extend and store replicate/strobe, so it can be unit-tested exhaustively.

Test Plan:
- SW 0x8765_4321 to 0x100, mem_ready immediate, ack 1 cycle later -> mem_addr=0x100, wstrb=1111, we=1; rsp_valid 4 cycles after accept, err=00, rdata=0.
- SB 0xAB to 0x103 -> wstrb=1000, wdata=0xABABABAB.
- LB from 0x102, mem_rdata=0x0080_0000 -> rsp_rdata=0xFFFFFF80.
- LBU from 0x102, same mem_rdata -> rsp_rdata=0x00000080.
- LH from 0x101 -> no mem_valid, rsp_valid 2 cycles after accept, err=01.
- Load funct3=011 -> no mem_valid, err=01.
- LW with mem_ready held low for 5 cycles -> mem_valid/mem_addr stable throughout; mem_rvalid with mem_err=1 -> err=10, rdata=0.
- TIMEOUT_CYCLES=4, no mem_rvalid -> err=11 after 4 DATA cycles, then req_ready=1; a late mem_rvalid is ignored.
- rst asserted while in DATA -> mem_valid=0, rsp_valid=0, req_ready=1 on release; the next request completes normally.
